mlp_result_collector: RTL and testbench

MLP_RESULT_COLLECTOR -- requirements
Module: mlp_result_collector

---
 rtl/mlp_result_collector.sv | 127 ++++++++++++
 tb/tb_mlp_result_collector.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_result_collector.sv
// Buffers result beats from the MVM NoC in a small FIFO and exposes the head entry,
// status and control to a host over an Avalon-MM slave with a level interrupt.
module mlp_result_collector #(
  parameter int DATAW = 128,
  parameter int DESTW = 12,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             axis_m_tvalid,
  output logic             axis_m_tready,
  input  logic [DATAW-1:0] axis_m_tdata,
  input  logic [DESTW-1:0] axis_m_tdest,
  input  logic             axis_m_tlast,
  input  logic [3:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int PADW = (DATAW > 128) ? DATAW : 128;

  typedef struct packed {
    logic [DESTW-1:0] dest;
    logic             last;
    logic [DATAW-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_nxt;
  logic [15:0]     frame_cnt;
  logic            underflow, irq_en, flush_pending;
  logic            empty, full;
  logic            dec_rd, dec_wr, push, pop_req, pop, flush_req, clr_stat;
  entry_t          head;
  logic [PADW-1:0] head_pad;
  logic [31:0]     rd_mux;
  logic            unused_wdata;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign dec_rd    = chipselect && read;
  assign dec_wr    = chipselect && write;
  assign push      = axis_m_tvalid && axis_m_tready;
  assign pop_req   = dec_wr && (address == 4'h6);
  // A pending flush owns the FIFO for its cycle; pops in that window are dropped silently.
  assign pop       = pop_req && !empty && !flush_pending;
  assign flush_req = dec_wr && (address == 4'h7) && writedata[1];
  assign clr_stat  = dec_wr && (address == 4'h0);
  assign head      = mem[rd_ptr];
  assign head_pad  = PADW'(head.data);
  assign unused_wdata = ^writedata[31:2];

  always_comb begin
    count_nxt = count;
    if (flush_pending)      count_nxt = '0;
    else if (push && !pop)  count_nxt = count + CW'(1);
    else if (pop && !push)  count_nxt = count - CW'(1);
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      4'h0: begin
        rd_mux[7:0]   = 8'(count);
        rd_mux[8]     = empty;
        rd_mux[9]     = full;
        rd_mux[10]    = underflow;
        rd_mux[31:16] = frame_cnt;
      end
      4'h1: if (!empty) rd_mux = head_pad[31:0];
      4'h2: if (!empty) rd_mux = head_pad[63:32];
      4'h3: if (!empty) rd_mux = head_pad[95:64];
      4'h4: if (!empty) rd_mux = head_pad[127:96];
      4'h5: if (!empty) begin
        rd_mux[DESTW-1:0] = head.dest;
        rd_mux[16]        = head.last;
      end
      4'h7: rd_mux[0] = irq_en;
      default: rd_mux = '0;
    endcase
  end

  // Storage is deliberately left unreset; pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (push && reset_n) mem[wr_ptr] <= '{dest: axis_m_tdest, last: axis_m_tlast, data: axis_m_tdata};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      frame_cnt     <= '0;
      underflow     <= 1'b0;
      irq_en        <= 1'b0;
      flush_pending <= 1'b0;
      readdata      <= '0;
      irq           <= 1'b0;
      axis_m_tready <= 1'b0;
    end else begin
      count         <= count_nxt;
      flush_pending <= flush_req;
      // Registered from next state, so a slot freed by a pop opens only on the following cycle.
      axis_m_tready <= (count_nxt != CW'(DEPTH)) && !flush_req;
      irq           <= irq_en && !empty;
      if (flush_pending) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      if (clr_stat)                       frame_cnt <= '0;
      else if (push && axis_m_tlast)      frame_cnt <= frame_cnt + 16'd1;
      if (clr_stat)                                  underflow <= 1'b0;
      else if (pop_req && empty && !flush_pending)   underflow <= 1'b1;
      if (dec_wr && (address == 4'h7)) irq_en <= writedata[0];
      if (dec_rd) readdata <= rd_mux;
    end
  end
endmodule

// File: tb/tb_mlp_result_collector.sv
// Directed bench for mlp_result_collector: a queue-based reference model checked every
// cycle, plus literal register values that pin the model.
module tb_mlp_result_collector;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         tvalid, tready, tlast;
  logic [127:0] tdata;
  logic [11:0]  tdest;
  logic [3:0]   address;
  logic         cs, rd, wr;
  logic [31:0]  writedata, readdata;
  logic         irq;

  mlp_result_collector #(.DATAW(128), .DESTW(12), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .axis_m_tvalid(tvalid), .axis_m_tready(tready), .axis_m_tdata(tdata),
    .axis_m_tdest(tdest), .axis_m_tlast(tlast),
    .address(address), .chipselect(cs), .read(rd), .write(wr),
    .writedata(writedata), .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic [11:0]  dest;
    logic         last;
  } ent_t;

  ent_t        q[$];
  logic        m_under = 0, m_irq_en = 0, m_flush = 0;
  logic [15:0] m_frames = 0;
  logic        exp_tready = 0, exp_irq = 0;
  logic [31:0] exp_rd = 0;
  int          errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    logic [31:0] r;
    int n;
    ent_t h;
    r = '0;
    n = q.size();
    if (n > 0) h = q[0];
    case (a)
      4'h0: r = {m_frames, 5'b0, m_under, (n == DEPTH), (n == 0), 8'(n)};
      4'h1, 4'h2, 4'h3, 4'h4: if (n > 0) r = 32'(h.d >> (32 * (int'(a) - 1)));
      4'h5: if (n > 0) r = {15'b0, h.last, 4'b0, h.dest};
      4'h7: r = {31'b0, m_irq_en};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Advances the model by one clock edge using the inputs the bench is driving.
  task automatic model_step();
    logic push, popr, fl;
    int n;
    if (!reset_n) begin
      q.delete();
      m_under = 0; m_frames = 0; m_irq_en = 0; m_flush = 0;
      exp_rd = 0; exp_irq = 0; exp_tready = 0;
      return;
    end
    n = q.size();
    if (cs && rd) exp_rd = model_read(address);
    exp_irq = m_irq_en && (n > 0);
    push = tvalid && exp_tready;
    popr = cs && wr && (address == 4'h6);
    if (m_flush) q.delete();
    else begin
      if (popr) begin
        if (n > 0) void'(q.pop_front());
        else m_under = 1;
      end
      if (push) q.push_back('{tdata, tdest, tlast});
    end
    if (push && tlast) m_frames = m_frames + 16'd1;
    fl = 0;
    if (cs && wr && address == 4'h0) begin m_under = 0; m_frames = 0; end
    if (cs && wr && address == 4'h7) begin m_irq_en = writedata[0]; fl = writedata[1]; end
    m_flush = fl;
    exp_tready = (q.size() < DEPTH) && !m_flush;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("tready", {31'b0, tready}, {31'b0, exp_tready});
    chk("irq", {31'b0, irq}, {31'b0, exp_irq});
    chk("readdata", readdata, exp_rd);
  endtask

  // Presents a beat and returns at the negedge after it is accepted; tvalid stays high.
  task automatic push_beat(input logic [127:0] d, input logic [11:0] dst, input logic lst);
    int b;
    tvalid = 1; tdata = d; tdest = dst; tlast = lst;
    b = 0;
    while (!tready && b < 50) begin tick(); b++; end
    if (!tready) chk("push_timeout", {31'b0, tready}, 32'd1);
    tick();
  endtask

  task automatic rd_reg(input logic [3:0] a, input logic [31:0] lit, input string nm);
    cs = 1; rd = 1; address = a;
    tick();
    cs = 0; rd = 0;
    chk(nm, readdata, lit);
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
    cs = 1; wr = 1; address = a; writedata = d;
    tick();
    cs = 0; wr = 0;
  endtask

  initial begin
    reset_n = 0; tvalid = 0; tdata = '0; tdest = '0; tlast = 0;
    address = '0; cs = 0; rd = 0; wr = 0; writedata = '0;
    repeat (3) tick();
    chk("rst_tready", {31'b0, tready}, 32'd0);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    reset_n = 1;
    tick();
    chk("tready_after_rst", {31'b0, tready}, 32'd1);

    // single beat, head decode
    push_beat(128'h3FF, 12'h005, 1);
    tvalid = 0;
    rd_reg(4'h0, 32'h0001_0001, "status_one");
    rd_reg(4'h1, 32'h0000_03FF, "head_w0");
    rd_reg(4'h2, 32'h0000_0000, "head_w1");
    rd_reg(4'h5, 32'h0001_0005, "head_tag");
    rd_reg(4'hF, 32'h0000_0000, "unmapped");
    wr_reg(4'h6, 0);

    // fill to full, hold a ninth beat, pop to let it in
    for (int i = 0; i < DEPTH; i++) push_beat(128'h100 + 128'(i), 12'(i), 0);
    tdata = 128'h1FF; tdest = 12'h0FF; tlast = 0;
    repeat (3) tick();
    chk("full_tready", {31'b0, tready}, 32'd0);
    rd_reg(4'h0, 32'h0001_0208, "status_full");
    cs = 1; wr = 1; address = 4'h6;
    tick();
    cs = 0; wr = 0;
    chk("tready_after_pop", {31'b0, tready}, 32'd1);
    tick();
    tvalid = 0;
    rd_reg(4'h0, 32'h0001_0208, "status_refill");
    rd_reg(4'h1, 32'h0000_0101, "head_after_pop");
    for (int i = 0; i < DEPTH; i++) wr_reg(4'h6, 0);
    rd_reg(4'h0, 32'h0001_0100, "status_drained");

    // underflow sticky
    wr_reg(4'h6, 0);
    rd_reg(4'h0, 32'h0001_0500, "status_underflow");
    rd_reg(4'h1, 32'h0000_0000, "head_empty");
    wr_reg(4'h0, 0);
    rd_reg(4'h0, 32'h0000_0100, "status_cleared");

    // simultaneous push and pop
    push_beat(128'hA, 12'h00A, 0);
    push_beat(128'hB, 12'h00B, 0);
    push_beat(128'hC, 12'h00C, 0);
    tdata = 128'hD; tdest = 12'h00D;
    cs = 1; wr = 1; address = 4'h6;
    tick();
    tvalid = 0; cs = 0; wr = 0;
    rd_reg(4'h0, 32'h0000_0003, "status_pushpop");
    rd_reg(4'h1, 32'h0000_000B, "head_pushpop");

    // interrupt and flush
    wr_reg(4'h6, 0);
    wr_reg(4'h7, 32'h1);
    tick();
    chk("irq_on", {31'b0, irq}, 32'd1);
    rd_reg(4'h7, 32'h0000_0001, "ctrl_irq_en");
    wr_reg(4'h7, 32'h3);
    chk("flush_tready_low", {31'b0, tready}, 32'd0);
    tick();
    chk("flush_tready_back", {31'b0, tready}, 32'd1);
    tick();
    chk("flush_irq_off", {31'b0, irq}, 32'd0);
    rd_reg(4'h0, 32'h0000_0100, "status_flushed");

    // reset mid-operation with a beat presented during reset
    for (int i = 0; i < 5; i++) push_beat(128'h200 + 128'(i), 12'h001, 0);
    tvalid = 0;
    rd_reg(4'h0, 32'h0000_0005, "status_five");
    reset_n = 0; tvalid = 1; tdata = 128'h555; tlast = 1;
    tick();
    chk("midrst_readdata", readdata, 32'd0);
    chk("midrst_irq", {31'b0, irq}, 32'd0);
    chk("midrst_tready", {31'b0, tready}, 32'd0);
    tick();
    reset_n = 1; tvalid = 0;
    tick();
    rd_reg(4'h0, 32'h0000_0100, "status_after_rst");

    // frame counter wrap: 0xFFFF frames streamed with push+pop each cycle
    tvalid = 1; tdata = '0; tdest = '0; tlast = 1;
    tick();
    cs = 1; wr = 1; address = 4'h6;
    repeat (16'hFFFE) tick();
    tvalid = 0; cs = 0; wr = 0;
    rd_reg(4'h0, 32'hFFFF_0001, "frames_ffff");
    push_beat(128'h1, 12'h001, 1);
    tvalid = 0;
    rd_reg(4'h0, 32'h0000_0002, "frames_wrap");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
